// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer
// Debounces the keypad scanner output, turns each accepted press into one
// edit action on a four-digit BCD entry buffer, drives four active-low
// seven-segment displays and commits the buffer on the enter key.
// Optional feature macro: AUTO_REPEAT_EN (held digit/backspace keys repeat
// every REPEAT_CYCLES clocks). Without it each press yields exactly one action.

module keypad_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic [7:0]  out_7seg1,
    output logic [7:0]  out_7seg2,
    output logic [7:0]  out_7seg3,
    output logic [7:0]  out_7seg4,
    output logic [2:0]  digit_count,
    output logic [15:0] entry_value,
    output logic        entry_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values the debounce and repeat counters cannot honour
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("keypad_entry_buffer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    logic       valid_meta_q, valid_meta_d;
    logic       valid_sync_q, valid_sync_d;
    logic [3:0] code_meta_q, code_meta_d;
    logic [3:0] code_sync_q, code_sync_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic             fire_q, fire_d;
    logic [3:0]       act_code_q, act_code_d;

    logic [15:0] buf_q, buf_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] entry_value_q, entry_value_d;
    logic        entry_valid_q, entry_valid_d;
    logic [7:0]  seg1_q, seg1_d;
    logic [7:0]  seg2_q, seg2_d;
    logic [7:0]  seg3_q, seg3_d;
    logic [7:0]  seg4_q, seg4_d;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             repeatable;

    assign repeatable = (cand_q <= 4'd9) || (cand_q == 4'hB);
`endif

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for a decimal digit
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Two-flop synchronizer stages for the asynchronous scanner outputs
    always_comb begin
        valid_meta_d = key_valid;
        valid_sync_d = valid_meta_q;
        code_meta_d  = key_code;
        code_sync_d  = code_meta_q;
    end

    // Debounce FSM: accept a press once the code is stable, then wait for a clean release
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        fire_d     = 1'b0;
        act_code_d = act_code_q;
`ifdef AUTO_REPEAT_EN
        rpt_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_sync_q) begin
                    cand_d  = code_sync_q;
                    cnt_d   = CNT_ONE;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!valid_sync_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (code_sync_q != cand_q) begin
                    cand_d = code_sync_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d      = cnt_q + CNT_ONE;
                    fire_d     = 1'b1;
                    act_code_d = cand_q;
                    state_d    = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!valid_sync_q) begin
                    cnt_d   = CNT_ONE;
                    state_d = REL_DB;
                end
`ifdef AUTO_REPEAT_EN
                else if (repeatable) begin
                    if (rpt_q == RPT_LAST) begin
                        fire_d     = 1'b1;
                        act_code_d = cand_q;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
`endif
            end
            REL_DB: begin
                if (valid_sync_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Apply the accepted key action to the digit buffer and the committed entry
    always_comb begin
        buf_d         = buf_q;
        count_d       = count_q;
        entry_value_d = entry_value_q;
        entry_valid_d = 1'b0;
        if (fire_q) begin
            if (act_code_q <= 4'd9) begin
                if (count_q < 3'd4) begin
                    buf_d   = {buf_q[11:0], act_code_q};
                    count_d = count_q + 3'd1;
                end
            end else begin
                case (act_code_q)
                    4'hA: begin
                        if (count_q != 3'd0) begin
                            entry_value_d = buf_q;
                            entry_valid_d = 1'b1;
                            buf_d         = '0;
                            count_d       = '0;
                        end
                    end
                    4'hB: begin
                        if (count_q != 3'd0) begin
                            buf_d   = {4'h0, buf_q[15:4]};
                            count_d = count_q - 3'd1;
                        end
                    end
                    4'hC: begin
                        buf_d   = '0;
                        count_d = '0;
                    end
                    default: begin
                        buf_d = buf_q;
                    end
                endcase
            end
        end
    end

    // Display only the occupied positions; empty positions are blanked
    always_comb begin
        seg1_d = (count_q >= 3'd1) ? seg_of(buf_q[3:0])   : 8'hFF;
        seg2_d = (count_q >= 3'd2) ? seg_of(buf_q[7:4])   : 8'hFF;
        seg3_d = (count_q >= 3'd3) ? seg_of(buf_q[11:8])  : 8'hFF;
        seg4_d = (count_q >= 3'd4) ? seg_of(buf_q[15:12]) : 8'hFF;
    end

    // State registers with synchronous active-low reset that overrides every event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_meta_q  <= 1'b0;
            valid_sync_q  <= 1'b0;
            code_meta_q   <= '0;
            code_sync_q   <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            fire_q        <= 1'b0;
            act_code_q    <= '0;
            buf_q         <= '0;
            count_q       <= '0;
            entry_value_q <= '0;
            entry_valid_q <= 1'b0;
            seg1_q        <= 8'hFF;
            seg2_q        <= 8'hFF;
            seg3_q        <= 8'hFF;
            seg4_q        <= 8'hFF;
        end else begin
            valid_meta_q  <= valid_meta_d;
            valid_sync_q  <= valid_sync_d;
            code_meta_q   <= code_meta_d;
            code_sync_q   <= code_sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            fire_q        <= fire_d;
            act_code_q    <= act_code_d;
            buf_q         <= buf_d;
            count_q       <= count_d;
            entry_value_q <= entry_value_d;
            entry_valid_q <= entry_valid_d;
            seg1_q        <= seg1_d;
            seg2_q        <= seg2_d;
            seg3_q        <= seg3_d;
            seg4_q        <= seg4_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Repeat timer for a held digit or backspace key
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign out_7seg1   = seg1_q;
    assign out_7seg2   = seg2_q;
    assign out_7seg3   = seg3_q;
    assign out_7seg4   = seg4_q;
    assign digit_count = count_q;
    assign entry_value = entry_value_q;
    assign entry_valid = entry_valid_q;

endmodule
